// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier reusing one WIDTH-bit ripple adder.
// Optional MULT_ZERO_SKIP_EN: zero operands bypass the RUN phase and finish in one edge.

module shift_add_mult_rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] c;

  assign c[0] = ci;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[W];
endmodule

module shift_add_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;

  assign addend = q_q[0] ? m_q : '0;

  shift_add_mult_rca #(.W(WIDTH)) u_add (
    .a  (acc_q),
    .b  (addend),
    .ci (1'b0),
    .s  (sum),
    .co (carry)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = A;
          q_d     = B;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = RUN;
`ifdef MULT_ZERO_SKIP_EN
          if ((A == '0) || (B == '0)) begin
            state_d = DONE;
            p_d     = '0;
          end
`endif
        end
      end
      RUN: begin
        // carry-out becomes the new ACC MSB, so the product never truncates
        acc_d = {carry, sum[WIDTH-1:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          p_d     = {acc_d, q_d};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign P    = p_q;
endmodule
